// File: rtl/iob_vex_bus_arbiter_pkg.sv
// Shared encodings and default widths for the ibus/dbus to IOb arbiter.
package iob_vex_bus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_t;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Converts a raw winner/owner bit into the owner encoding.
    function automatic owner_t to_owner(input logic b);
        return b ? OWN_DBUS : OWN_IBUS;
    endfunction

endpackage

// File: rtl/iob_vex_bus_arbiter_pick2.sv
// Two-way winner selection between ibus and dbus.
// Fixed dbus priority or round-robin against the last served bus.
module iob_arb_pick2
    import iob_vex_bus_arbiter_pkg::*;
#(
    parameter int unsigned DBUS_PRIO = 1
) (
    input  logic ibus_valid,
    input  logic dbus_valid,
    input  logic rr_last,
    output logic winner
);

    // Sole requester wins; a tie goes to dbus or to the bus not served last.
    always_comb begin
        winner = OWN_IBUS;
        if (dbus_valid && !ibus_valid) begin
            winner = OWN_DBUS;
        end else if (dbus_valid && ibus_valid) begin
            if (DBUS_PRIO != 0) begin
                winner = OWN_DBUS;
            end else begin
                winner = (to_owner(rr_last) == OWN_IBUS) ? OWN_DBUS : OWN_IBUS;
            end
        end
    end

endmodule

// File: rtl/iob_vex_bus_arbiter.sv
// Merges the VexRiscv ibus (read-only) and dbus onto one IOb native port.
// Grant is held until m_ready; the response is routed to the owner only.
module iob_vex_bus_arbiter
    import iob_vex_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned DBUS_PRIO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ibus_valid,
    input  logic [ADDR_W-1:0]   ibus_addr,
    output logic [DATA_W-1:0]   ibus_rdata,
    output logic                ibus_ready,
    input  logic                dbus_valid,
    input  logic [ADDR_W-1:0]   dbus_addr,
    input  logic [DATA_W-1:0]   dbus_wdata,
    input  logic [DATA_W/8-1:0] dbus_wstrb,
    output logic [DATA_W-1:0]   dbus_rdata,
    output logic                dbus_ready,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic                owner
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

    logic   winner;
    logic   any_valid;
    owner_t granted;

    iob_arb_pick2 #(
        .DBUS_PRIO(DBUS_PRIO)
    ) u_pick (
        .ibus_valid(ibus_valid),
        .dbus_valid(dbus_valid),
        .rr_last   (rr_last_q),
        .winner    (winner)
    );

    // Shared-port request mux and response routing to the granted owner.
    always_comb begin
        any_valid = ibus_valid | dbus_valid;
        granted   = (state_q == ST_BUSY) ? owner_q : to_owner(winner);
        if (state_q == ST_BUSY) begin
            m_valid = 1'b1;
            m_addr  = addr_q;
            m_wdata = wdata_q;
            m_wstrb = wstrb_q;
        end else begin
            m_valid = any_valid;
            if (to_owner(winner) == OWN_DBUS) begin
                m_addr  = dbus_addr;
                m_wdata = dbus_wdata;
                m_wstrb = dbus_wstrb;
            end else begin
                m_addr  = ibus_addr;
                m_wdata = '0;
                m_wstrb = '0;
            end
        end
        if (rst) begin
            m_valid = 1'b0;
        end
        // m_valid gating drops a stray m_ready seen while nothing is requested.
        ibus_ready = m_ready & m_valid & (granted == OWN_IBUS);
        dbus_ready = m_ready & m_valid & (granted == OWN_DBUS);
        ibus_rdata = m_rdata;
        dbus_rdata = m_rdata;
        owner      = owner_q;
    end

    // Next-state: latch the winner's request in IDLE unless it completes in place.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    owner_d = to_owner(winner);
                    if (m_ready) begin
                        // Zero-wait completion still counts as service for round-robin.
                        rr_last_d = to_owner(winner);
                    end else begin
                        state_d = ST_BUSY;
                        addr_d  = m_addr;
                        wdata_d = m_wdata;
                        wstrb_d = m_wstrb;
                    end
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    state_d   = ST_IDLE;
                    rr_last_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IBUS;
            rr_last_q <= OWN_IBUS;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_iob_vex_bus_arbiter.sv
// Scoreboard bench for iob_vex_bus_arbiter: instance A uses dbus priority,
// instance B uses round-robin.
module tb_iob_vex_bus_arbiter;

    typedef struct packed {
        logic        bus;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_ibus_valid, a_dbus_valid, a_ibus_ready, a_dbus_ready;
    logic [31:0] a_ibus_addr, a_dbus_addr, a_dbus_wdata, a_ibus_rdata, a_dbus_rdata;
    logic [3:0]  a_dbus_wstrb, a_m_wstrb;
    logic        a_m_valid, a_m_ready, a_owner;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

    logic        b_ibus_valid, b_dbus_valid, b_ibus_ready, b_dbus_ready;
    logic [31:0] b_ibus_addr, b_dbus_addr, b_dbus_wdata, b_ibus_rdata, b_dbus_rdata;
    logic [3:0]  b_dbus_wstrb, b_m_wstrb;
    logic        b_m_valid, b_m_ready, b_owner;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

    iob_vex_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DBUS_PRIO(1)) dut_a (
        .clk(clk), .rst(rst),
        .ibus_valid(a_ibus_valid), .ibus_addr(a_ibus_addr),
        .ibus_rdata(a_ibus_rdata), .ibus_ready(a_ibus_ready),
        .dbus_valid(a_dbus_valid), .dbus_addr(a_dbus_addr),
        .dbus_wdata(a_dbus_wdata), .dbus_wstrb(a_dbus_wstrb),
        .dbus_rdata(a_dbus_rdata), .dbus_ready(a_dbus_ready),
        .m_valid(a_m_valid), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_wstrb(a_m_wstrb), .m_rdata(a_m_rdata), .m_ready(a_m_ready),
        .owner(a_owner)
    );

    iob_vex_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DBUS_PRIO(0)) dut_b (
        .clk(clk), .rst(rst),
        .ibus_valid(b_ibus_valid), .ibus_addr(b_ibus_addr),
        .ibus_rdata(b_ibus_rdata), .ibus_ready(b_ibus_ready),
        .dbus_valid(b_dbus_valid), .dbus_addr(b_dbus_addr),
        .dbus_wdata(b_dbus_wdata), .dbus_wstrb(b_dbus_wstrb),
        .dbus_rdata(b_dbus_rdata), .dbus_ready(b_dbus_ready),
        .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_wstrb(b_m_wstrb), .m_rdata(b_m_rdata), .m_ready(b_m_ready),
        .owner(b_owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor for instance A: every ready pulse must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_ibus_ready || a_dbus_ready) begin
                chk("a_ready_exclusive", 32'(a_ibus_ready & a_dbus_ready), 32'd0);
                if (qa.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL a_spurious_ready: ibus_ready=%0b dbus_ready=%0b with nothing expected at %0t",
                             a_ibus_ready, a_dbus_ready, $time);
                end else begin
                    e = qa.pop_front();
                    chk("a_bus", 32'(a_dbus_ready), 32'(e.bus));
                    chk("a_rdata", e.bus ? a_dbus_rdata : a_ibus_rdata, e.rdata);
                    chk("a_addr", a_m_addr, e.addr);
                    chk("a_wstrb", 32'(a_m_wstrb), 32'(e.wstrb));
                    if (e.wstrb != 4'h0) chk("a_wdata", a_m_wdata, e.wdata);
                end
            end
        end
    end

    // Monitor for instance B.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_ibus_ready || b_dbus_ready) begin
                chk("b_ready_exclusive", 32'(b_ibus_ready & b_dbus_ready), 32'd0);
                if (qb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b_spurious_ready: ibus_ready=%0b dbus_ready=%0b with nothing expected at %0t",
                             b_ibus_ready, b_dbus_ready, $time);
                end else begin
                    e = qb.pop_front();
                    chk("b_bus", 32'(b_dbus_ready), 32'(e.bus));
                    chk("b_rdata", e.bus ? b_dbus_rdata : b_ibus_rdata, e.rdata);
                    chk("b_addr", b_m_addr, e.addr);
                    chk("b_wstrb", 32'(b_m_wstrb), 32'(e.wstrb));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Directed stimulus; the bench plays both requesters and the slave.
    initial begin
        logic exp_bus;
        a_ibus_valid = 0; a_ibus_addr = '0; a_dbus_valid = 0; a_dbus_addr = '0;
        a_dbus_wdata = '0; a_dbus_wstrb = '0; a_m_rdata = '0; a_m_ready = 0;
        b_ibus_valid = 0; b_ibus_addr = '0; b_dbus_valid = 0; b_dbus_addr = '0;
        b_dbus_wdata = '0; b_dbus_wstrb = '0; b_m_rdata = '0; b_m_ready = 0;

        // Reset state
        @(negedge clk);
        chk("rst_m_valid", 32'(a_m_valid), 32'd0);
        chk("rst_readies", 32'({a_ibus_ready, a_dbus_ready}), 32'd0);
        chk("rst_owner", 32'(a_owner), 32'd0);
        chk("rst_b_owner", 32'(b_owner), 32'd0);
        tick;
        tick; rst = 0;
        @(negedge clk);
        chk("idle_m_valid", 32'(a_m_valid), 32'd0);
        chk("idle_b_m_valid", 32'(b_m_valid), 32'd0);

        // Lone ibus read, three wait cycles
        tick; a_ibus_valid = 1; a_ibus_addr = 32'h100;
        @(negedge clk);
        chk("ibus_m_valid", 32'(a_m_valid), 32'd1);
        chk("ibus_m_addr", a_m_addr, 32'h100);
        chk("ibus_m_wstrb", 32'(a_m_wstrb), 32'd0);
        tick; a_ibus_addr = 32'h9999;
        @(negedge clk);
        chk("ibus_addr_latched", a_m_addr, 32'h100);
        chk("ibus_owner", 32'(a_owner), 32'd0);
        tick;
        tick;
        tick;
        qa.push_back('{bus: 1'b0, rdata: 32'hDEADBEEF, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0});
        a_m_ready = 1; a_m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ibus_no_dbus_ready", 32'(a_dbus_ready), 32'd0);
        tick; a_m_ready = 0; a_ibus_valid = 0; a_m_rdata = '0;
        @(negedge clk);
        chk("ibus_done_idle", 32'(a_m_valid), 32'd0);

        // Simultaneous requests, dbus priority
        tick;
        a_ibus_valid = 1; a_ibus_addr = 32'h200;
        a_dbus_valid = 1; a_dbus_addr = 32'h300; a_dbus_wdata = 32'h12345678; a_dbus_wstrb = 4'hF;
        qa.push_back('{bus: 1'b1, rdata: 32'h0, addr: 32'h300, wdata: 32'h12345678, wstrb: 4'hF});
        qa.push_back('{bus: 1'b0, rdata: 32'hCAFEF00D, addr: 32'h200, wdata: 32'h0, wstrb: 4'h0});
        @(negedge clk);
        chk("prio_m_addr", a_m_addr, 32'h300);
        chk("prio_m_wstrb", 32'(a_m_wstrb), 32'hF);
        tick;
        @(negedge clk);
        chk("prio_owner_dbus", 32'(a_owner), 32'd1);
        tick; a_m_ready = 1; a_m_rdata = 32'h0;
        tick; a_m_ready = 0; a_dbus_valid = 0; a_dbus_wstrb = 4'h0;
        @(negedge clk);
        chk("prio_ibus_next_valid", 32'(a_m_valid), 32'd1);
        chk("prio_ibus_next_addr", a_m_addr, 32'h200);
        chk("prio_ibus_next_wstrb", 32'(a_m_wstrb), 32'd0);
        tick;
        @(negedge clk);
        chk("prio_owner_ibus", 32'(a_owner), 32'd0);
        tick; a_m_ready = 1; a_m_rdata = 32'hCAFEF00D;
        tick; a_m_ready = 0; a_ibus_valid = 0; a_m_rdata = '0;

        // Round-robin on instance B, both buses continuously valid
        tick;
        b_ibus_valid = 1; b_ibus_addr = 32'h500;
        b_dbus_valid = 1; b_dbus_addr = 32'h600; b_dbus_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            exp_bus = (i % 2 == 0);
            tick;
            @(negedge clk);
            chk($sformatf("rr_owner_%0d", i), 32'(b_owner), 32'(exp_bus));
            tick;
            qb.push_back('{bus: exp_bus, rdata: 32'hA0 + 32'(i),
                           addr: exp_bus ? 32'h600 : 32'h500, wdata: 32'h0, wstrb: 4'h0});
            b_m_ready = 1; b_m_rdata = 32'hA0 + 32'(i);
            tick; b_m_ready = 0;
        end
        b_ibus_valid = 0; b_dbus_valid = 0;

        // Zero-wait dbus read completes in place
        tick;
        a_dbus_valid = 1; a_dbus_addr = 32'h40; a_dbus_wstrb = 4'h0;
        a_m_ready = 1; a_m_rdata = 32'h0BADF00D;
        qa.push_back('{bus: 1'b1, rdata: 32'h0BADF00D, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0});
        @(negedge clk);
        chk("zw_dbus_ready", 32'(a_dbus_ready), 32'd1);
        tick; a_dbus_valid = 0; a_m_ready = 0; a_m_rdata = '0;
        @(negedge clk);
        chk("zw_stays_idle", 32'(a_m_valid), 32'd0);

        // Reset in the middle of a BUSY ibus transaction
        tick; a_ibus_valid = 1; a_ibus_addr = 32'h700;
        tick;
        tick; rst = 1;
        @(negedge clk);
        chk("midrst_m_valid_in_rst", 32'(a_m_valid), 32'd0);
        tick; rst = 0; a_ibus_valid = 0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(a_m_valid), 32'd0);
        chk("midrst_readies", 32'({a_ibus_ready, a_dbus_ready}), 32'd0);
        chk("midrst_owner", 32'(a_owner), 32'd0);
        tick; a_m_ready = 1; a_m_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("stray_ready_ignored", 32'({a_ibus_ready, a_dbus_ready}), 32'd0);
        chk("stray_m_valid", 32'(a_m_valid), 32'd0);
        tick; a_m_ready = 0;

        tick;
        tick;
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
